// File: rtl/gpr_file_sb.sv
// Register file with NRD read ports, two write ports, write-through bypass and a zero register.
// Each register has a saturating pending-write counter so decode can stall on RAW hazards.
module gpr_file_sb #(
  parameter  int DATA_W = 32,
  parameter  int NREG   = 32,
  parameter  int NRD    = 2,
  parameter  int CNT_W  = 2,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_ready,
  input  logic                    wr0_en,
  input  logic [ADDR_W-1:0]       wr0_addr,
  input  logic [DATA_W-1:0]       wr0_data,
  input  logic                    wr1_en,
  input  logic [ADDR_W-1:0]       wr1_addr,
  input  logic [DATA_W-1:0]       wr1_data,
  input  logic                    iss_en,
  input  logic [ADDR_W-1:0]       iss_addr,
  output logic                    iss_ok,
  input  logic                    flush
);

  localparam int CW1 = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs    [NREG];
  logic [CNT_W-1:0]  cnt     [NREG];
  logic [CNT_W-1:0]  cnt_nxt [NREG];
  logic [CW1-1:0]    dec_cnt [NREG];
  logic [CW1-1:0]    sum_cnt [NREG];

  assign iss_ok = iss_en && !flush &&
                  ((iss_addr == '0) || (cnt[iss_addr] != CNT_MAX));

  // Write-port 1 is applied last so it wins on an address collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      if (wr0_en && (wr0_addr != '0)) regs[wr0_addr] <= wr0_data;
      if (wr1_en && (wr1_addr != '0)) regs[wr1_addr] <= wr1_data;
    end
  end

  // sum never exceeds MAX because an issue is refused once the counter is full.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      dec_cnt[r] = CW1'(wr0_en && (wr0_addr == ADDR_W'(r)))
                 + CW1'(wr1_en && (wr1_addr == ADDR_W'(r)));
      sum_cnt[r] = {1'b0, cnt[r]} + CW1'(iss_ok && (iss_addr == ADDR_W'(r)));
      if (flush || (r == 0) || (sum_cnt[r] <= dec_cnt[r])) cnt_nxt[r] = '0;
      else                                                  cnt_nxt[r] = CNT_W'(sum_cnt[r] - dec_cnt[r]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_data[k*DATA_W +: DATA_W] =
        (a == '0)                   ? '0       :
        (wr1_en && (wr1_addr == a)) ? wr1_data :
        (wr0_en && (wr0_addr == a)) ? wr0_data : regs[a];
    // Bypassed data is final only when it retires the last outstanding write.
    assign rd_ready[k] = (a == '0) || ({1'b0, cnt[a]} <= dec_cnt[a]);
  end

endmodule

// File: tb/tb_gpr_file_sb.sv
// Self-checking bench for gpr_file_sb: directed scenarios plus random traffic
// compared against a per-register data/pending-count reference model.
module tb_gpr_file_sb;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int NRD    = 2;
  localparam int CNT_W  = 2;
  localparam int ADDR_W = 5;
  localparam int MAXC   = 3;

  logic                  clk = 0;
  logic                  reset = 0;
  logic [NRD*ADDR_W-1:0] rd_addr = '0;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_ready;
  logic                  wr0_en = 0, wr1_en = 0, iss_en = 0, flush = 0;
  logic [ADDR_W-1:0]     wr0_addr = '0, wr1_addr = '0, iss_addr = '0;
  logic [DATA_W-1:0]     wr0_data = '0, wr1_data = '0;
  logic                  iss_ok;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          mcnt [NREG];
  logic [31:0] mreg [NREG];

  gpr_file_sb #(.DATA_W(DATA_W), .NREG(NREG), .NRD(NRD), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ok(iss_ok), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int n_wr(input int a);
    return int'(wr0_en && (wr0_addr == 5'(a))) + int'(wr1_en && (wr1_addr == 5'(a)));
  endfunction

  function automatic logic [31:0] exp_rd(input int a);
    if (a == 0) return 32'h0;
    if (wr1_en && (wr1_addr == 5'(a))) return wr1_data;
    if (wr0_en && (wr0_addr == 5'(a))) return wr0_data;
    return mreg[a];
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) begin
      mcnt[r] = 0;
      mreg[r] = 32'h0;
    end
  endtask

  task automatic idle();
    wr0_en = 0; wr1_en = 0; iss_en = 0; flush = 0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {5'(a1), 5'(a0)};
  endtask

  // Called just after a negedge with inputs applied: check outputs, clock, update model.
  task automatic step();
    logic [NRD-1:0] er;
    logic           eok;
    int             a, d;
    #2;
    for (int k = 0; k < NRD; k++) begin
      a = int'(rd_addr[k*ADDR_W +: ADDR_W]);
      chk("rd_data", 64'(rd_data[k*DATA_W +: DATA_W]), 64'(exp_rd(a)));
      er[k] = (a == 0) || (mcnt[a] <= n_wr(a));
    end
    chk("rd_ready", 64'(rd_ready), 64'(er));
    eok = iss_en && !flush && ((iss_addr == 0) || (mcnt[iss_addr] < MAXC));
    chk("iss_ok", 64'(iss_ok), 64'(eok));
    @(posedge clk);
    for (int r = 1; r < NREG; r++) begin
      if (flush) mcnt[r] = 0;
      else begin
        d = mcnt[r] + int'(eok && (iss_addr == 5'(r))) - n_wr(r);
        mcnt[r] = (d < 0) ? 0 : d;
      end
    end
    if (wr0_en && wr0_addr != 0) mreg[wr0_addr] = wr0_data;
    if (wr1_en && wr1_addr != 0) mreg[wr1_addr] = wr1_data;
    @(negedge clk);
  endtask

  initial begin
    model_clear();
    set_rd(31, 5);
    #3;
    chk("rst_rd0", 64'(rd_data[31:0]), 64'h0);
    chk("rst_rd1", 64'(rd_data[63:32]), 64'h0);
    chk("rst_ready", 64'(rd_ready), 64'h3);
    chk("rst_iss_ok", 64'(iss_ok), 64'h0);
    @(negedge clk); @(negedge clk);
    reset = 1;

    // Prior data, then async reset mid-cycle wipes it.
    wr0_en = 1; wr0_addr = 31; wr0_data = 32'hDEAD_BEEF; set_rd(31, 0);
    step();
    idle(); step();
    chk("pre_rst_r31", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
    #1 reset = 0;
    #1;
    chk("async_rst_rd", 64'(rd_data[31:0]), 64'h0);
    chk("async_rst_ready", 64'(rd_ready), 64'h3);
    model_clear();
    @(negedge clk); reset = 1;
    step();
    chk("post_rst_r31", 64'(rd_data[31:0]), 64'h0);

    // Bypass then stored value.
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'h1234; set_rd(5, 5);
    #2 chk("bypass_r5", 64'(rd_data[31:0]), 64'h1234);
    step();
    idle(); #2 chk("stored_r5", 64'(rd_data[63:32]), 64'h1234);
    step();

    // Same-address write priority; reg0 write ignored.
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'hAAAA;
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'h5555; set_rd(7, 0);
    #2 chk("wr_prio_bypass", 64'(rd_data[31:0]), 64'h5555);
    step();
    idle(); #2 chk("wr_prio_stored", 64'(rd_data[31:0]), 64'h5555);
    step();
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFF; set_rd(0, 0);
    #2 chk("reg0_bypass", 64'(rd_data[31:0]), 64'h0);
    step();
    idle(); step();

    // Saturation at MAX, then drain with writes.
    set_rd(3, 0);
    for (int i = 0; i < 3; i++) begin
      iss_en = 1; iss_addr = 3;
      step();
    end
    #2 chk("sat_iss_ok", 64'(iss_ok), 64'h0);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      wr1_en = 1; wr1_addr = 3; wr1_data = 32'h300 + 32'(i);
      #2 chk("drain_ready", 64'(rd_ready[0]), (i == 2) ? 64'h1 : 64'h0);
      step();
    end
    idle(); step();

    // Issue + write same cycle keeps cnt; flush clears.
    iss_en = 1; iss_addr = 9; set_rd(9, 9); step();
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'h99; step();
    idle(); #2 chk("iss_wr_pending", 64'(rd_ready), 64'h0);
    step();
    flush = 1; iss_en = 1; iss_addr = 9;
    #2 chk("flush_iss_ok", 64'(iss_ok), 64'h0);
    step();
    idle(); #2 chk("flush_ready", 64'(rd_ready), 64'h3);
    step();

    // Write with no matching issue; then reset with pending counters.
    wr0_en = 1; wr0_addr = 4; wr0_data = 32'h4444; set_rd(4, 10); step();
    iss_en = 1; iss_addr = 10; wr0_en = 0; step();
    idle(); #2 chk("r4_no_iss", 64'({rd_ready[0], rd_data[31:0]}), 64'h1_0000_4444);
    chk("r10_pending", 64'(rd_ready[1]), 64'h0);
    step();
    #1 reset = 0;
    #1 chk("rst_r4", 64'(rd_data[31:0]), 64'h0);
    chk("rst_r10_ready", 64'(rd_ready), 64'h3);
    model_clear();
    @(negedge clk); reset = 1;
    step();

    // Random traffic with addresses concentrated to create hazards.
    for (int n = 0; n < 600; n++) begin
      wr0_en   = ($urandom_range(0, 2) == 0);
      wr1_en   = ($urandom_range(0, 2) == 0);
      iss_en   = ($urandom_range(0, 1) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      wr0_addr = 5'($urandom_range(0, 7));
      wr1_addr = 5'($urandom_range(0, 7));
      iss_addr = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) wr0_addr = 5'($urandom_range(0, 31));
      wr0_data = $urandom;
      wr1_data = $urandom;
      set_rd($urandom_range(0, 7), $urandom_range(0, 31));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
